// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the EXU multiply/divide sequencer and its borrowed ALU adder port.
package ysyx_24080006_pkg;

   localparam int MDU_ITER = 32;

   // Encoding follows RV32M funct3 so the decoder can pass it straight through.
   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_NEG_A  = 3'd1,
      S_NEG_B  = 3'd2,
      S_MUL    = 3'd3,
      S_DIV    = 3'd4,
      S_FIX_LO = 3'd5,
      S_FIX_HI = 3'd6,
      S_DONE   = 3'd7
   } mdu_state_e;

   typedef struct packed {
      logic [32:0] a;
      logic [32:0] b;
   } mdu2alu_t;

   typedef struct packed {
      logic [33:0] res_34;
      logic [31:0] res_32;
      logic        not_zero;
   } alu2mdu_t;

endpackage

// File: rtl/ysyx_24080006_mdu_dec.sv
// Combinational op decoder for the multiply/divide sequencer.
module ysyx_24080006_mdu_dec
   import ysyx_24080006_pkg::*;
(
   input  mdu_op_e op,
   output logic    is_div,
   output logic    is_rem,
   output logic    want_hi,
   output logic    a_signed,
   output logic    b_signed
);

   always_comb begin
      is_div   = 1'b0;
      is_rem   = 1'b0;
      want_hi  = 1'b0;
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op)
         MDU_MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
         MDU_MULH:   begin want_hi = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         MDU_MULHSU: begin want_hi = 1'b1; a_signed = 1'b1; end
         MDU_MULHU:  want_hi = 1'b1;
         MDU_DIV:    begin is_div = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         MDU_DIVU:   is_div = 1'b1;
         MDU_REM:    begin is_div = 1'b1; is_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         MDU_REMU:   begin is_div = 1'b1; is_rem = 1'b1; end
         default:    is_div = 1'b0;
      endcase
   end

endmodule

// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide sequencer that borrows the ALU's 34-bit adder.
// Optional YSYX_24080006_MDU_ZERO_BYPASS_EN: zero-operand requests finish at T+1.
module ysyx_24080006_mdu
   import ysyx_24080006_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  mdu_op_e         op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            mdu_enable,
   output mdu2alu_t        mdu2alu,
   input  alu2mdu_t        alu2mdu
);

   // Handshake: a request moves on in_valid && in_ready; a result moves on out_valid && out_ready.
   mdu_state_e state, state_d;
   mdu_op_e    op_q, dec_op;
   logic [31:0] hi, lo, dsr, hi_d, lo_d, dsr_d;
   logic [4:0]  cnt;
   logic        neg_b_q, res_neg, zero_lo;
   logic        is_div, is_rem, want_hi, a_signed, b_signed;
   logic        accept, s1, s2, div_zero, zero_hit, last, carry, qbit;
   logic [31:0] sum, p_lo, neg_src_a, neg_src_b, fix_src;
   mdu_state_e  work_st;
   logic        unused_alu;

   assign dec_op = (state == S_IDLE) ? op : op_q;

   ysyx_24080006_mdu_dec u_dec (
      .op       (dec_op),
      .is_div   (is_div),
      .is_rem   (is_rem),
      .want_hi  (want_hi),
      .a_signed (a_signed),
      .b_signed (b_signed)
   );

   assign accept   = in_valid & in_ready & ~flush;
   assign s1       = a_signed & rs1[31];
   assign s2       = b_signed & rs2[31];
   assign div_zero = is_div & (rs2 == '0);
`ifdef YSYX_24080006_MDU_ZERO_BYPASS_EN
   assign zero_hit = is_div ? ((rs1 == '0) & (rs2 != '0)) : ((rs1 == '0) | (rs2 == '0));
`else
   assign zero_hit = 1'b0;
`endif
   assign work_st  = is_div ? S_DIV : S_MUL;
   assign last     = (cnt == 5'd0);
   assign carry    = alu2mdu.res_34[33];
   assign sum      = alu2mdu.res_32;
   assign unused_alu = ^alu2mdu.res_34[32:0];

   // lo holds the multiplier / dividend, dsr the multiplicand / divisor.
   assign p_lo      = {hi[30:0], lo[31]};
   assign qbit      = hi[31] | carry;
   assign neg_src_a = is_div ? lo : dsr;
   assign neg_src_b = is_div ? dsr : lo;
   assign fix_src   = is_rem ? hi : lo;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:
            if (accept) begin
               if (div_zero || zero_hit) state_d = S_DONE;
               else if (s1)              state_d = S_NEG_A;
               else if (s2)              state_d = S_NEG_B;
               else                      state_d = work_st;
            end
         S_NEG_A:  state_d = neg_b_q ? S_NEG_B : work_st;
         S_NEG_B:  state_d = work_st;
         S_MUL, S_DIV:
            if (last) state_d = res_neg ? S_FIX_LO : S_DONE;
         S_FIX_LO: state_d = want_hi ? S_FIX_HI : S_DONE;
         S_FIX_HI: state_d = S_DONE;
         S_DONE:   if (out_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // Adder encodings: the LSB pair forms the carry-in (1+1 carries, 1+0 does not).
   always_comb begin
      in_ready   = (state == S_IDLE);
      out_valid  = (state == S_DONE);
      mdu_enable = 1'b0;
      mdu2alu    = '0;
      case (state)
         S_NEG_A:  begin mdu_enable = 1'b1; mdu2alu.a = 33'd1; mdu2alu.b = ~{neg_src_a, 1'b0}; end
         S_NEG_B:  begin mdu_enable = 1'b1; mdu2alu.a = 33'd1; mdu2alu.b = ~{neg_src_b, 1'b0}; end
         S_MUL:    begin mdu_enable = 1'b1; mdu2alu.a = {hi, 1'b1}; mdu2alu.b = {lo[0] ? dsr : 32'd0, 1'b0}; end
         S_DIV:    begin mdu_enable = 1'b1; mdu2alu.a = {p_lo, 1'b1}; mdu2alu.b = ~{dsr, 1'b0}; end
         S_FIX_LO: begin mdu_enable = 1'b1; mdu2alu.a = 33'd1; mdu2alu.b = ~{fix_src, 1'b0}; end
         S_FIX_HI: begin mdu_enable = 1'b1; mdu2alu.a = {~hi, 1'b1}; mdu2alu.b = {32'd0, zero_lo}; end
         default:  mdu_enable = 1'b0;
      endcase
   end

   always_comb begin
      hi_d  = hi;
      lo_d  = lo;
      dsr_d = dsr;
      case (state)
         S_IDLE:
            if (accept) begin
               hi_d  = '0;
               lo_d  = is_div ? rs1 : rs2;
               dsr_d = is_div ? rs2 : rs1;
               if (div_zero) begin
                  hi_d = rs1;
                  lo_d = '1;
               end else if (zero_hit) begin
                  lo_d = '0;
               end
            end
         S_NEG_A:  if (is_div) lo_d = sum; else dsr_d = sum;
         S_NEG_B:  if (is_div) dsr_d = sum; else lo_d = sum;
         S_MUL:    begin hi_d = {carry, sum[31:1]}; lo_d = {sum[0], lo[31:1]}; end
         S_DIV:    begin hi_d = qbit ? sum : p_lo; lo_d = {lo[30:0], qbit}; end
         S_FIX_LO: if (is_rem) hi_d = sum; else lo_d = sum;
         S_FIX_HI: hi_d = sum;
         default:  hi_d = hi;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hi         <= '0;
         lo         <= '0;
         dsr        <= '0;
         cnt        <= 5'(MDU_ITER - 1);
         op_q       <= MDU_MUL;
         neg_b_q    <= 1'b0;
         res_neg    <= 1'b0;
         zero_lo    <= 1'b0;
         out_result <= '0;
      end else begin
         hi  <= hi_d;
         lo  <= lo_d;
         dsr <= dsr_d;
         if (accept) begin
            op_q    <= op;
            neg_b_q <= s2;
            res_neg <= is_rem ? s1 : (s1 ^ s2);
            cnt     <= 5'(MDU_ITER - 1);
         end
         if (state == S_MUL || state == S_DIV) cnt <= cnt - 5'd1;
         // Negation preserves zero, so the FIX_LO adder result tells us whether lo was zero.
         if (state == S_FIX_LO) zero_lo <= ~alu2mdu.not_zero;
         if (state_d == S_DONE && state != S_DONE)
            out_result <= (want_hi | is_rem) ? hi_d : lo_d;
      end
   end

endmodule
